// File: rtl/preg_alloc_ctrl.sv
// Physical-register allocation controller.
// Arbitrates two rename lanes onto a single free-list allocate port (one
// allocation every two cycles) and funnels commit-time frees, plus registers
// recovered from flushed allocations, through a small FIFO into the free list.
module preg_alloc_ctrl #(
    parameter int PREG_W      = 6,
    parameter int FREEQ_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    output logic [1:0]        rsp_valid,
    output logic [PREG_W-1:0] rsp_phys,
    output logic              rsp_fail,
    output logic              fl_alloc_en,
    input  logic [PREG_W-1:0] fl_alloc_phys,
    input  logic              fl_alloc_valid,
    input  logic [1:0]        cm_free_valid,
    input  logic [PREG_W-1:0] cm_free_phys0,
    input  logic [PREG_W-1:0] cm_free_phys1,
    output logic              cm_free_ready,
    output logic              fl_free_en,
    output logic [PREG_W-1:0] fl_free_phys,
    input  logic              flush,
    output logic              busy
);

    localparam int PTR_W = $clog2(FREEQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

    state_t state_reg, state_next;
    logic   rr_reg, rr_next;        // lane holding priority
    logic   owner_reg, owner_next;  // lane awaiting the outstanding response

    logic   any_req;
    logic   grant_lane;
    logic   grant_fire;
    logic   resp_fire;
    logic   recover_push;

    // Free queue storage and bookkeeping
    logic [PREG_W-1:0] fq_mem [FREEQ_DEPTH];
    logic [PTR_W-1:0]  head_reg, head_next;
    logic [PTR_W-1:0]  tail_reg, tail_next;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic [1:0]        push_cnt;
    logic [PREG_W-1:0] push_data0, push_data1;
    logic              pop;

    // Round-robin choice: the priority lane wins if it asks, else the other one
    assign any_req    = |req_valid;
    assign grant_lane = req_valid[rr_reg] ? rr_reg : ~rr_reg;
    assign grant_fire = !reset && (state_reg == ST_IDLE) && !flush && any_req;
    assign resp_fire  = !reset && (state_reg == ST_WAIT) && !flush;

    // FSM state, arbitration pointer and owner registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            rr_reg    <= 1'b0;
            owner_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            rr_reg    <= rr_next;
            owner_reg <= owner_next;
        end
    end

    // Next-state logic: a grant moves to WAIT, WAIT always returns to IDLE
    always_comb begin
        state_next = state_reg;
        rr_next    = rr_reg;
        owner_next = owner_reg;
        case (state_reg)
            ST_IDLE: begin
                if (grant_fire) begin
                    state_next = ST_WAIT;
                    rr_next    = ~grant_lane;
                    owner_next = grant_lane;
                end
            end
            ST_WAIT: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // FSM outputs: allocate strobe, response payload and flush recovery
    always_comb begin
        fl_alloc_en  = 1'b0;
        rsp_fail     = 1'b0;
        rsp_phys     = '0;
        recover_push = 1'b0;
        if (!reset) begin
            case (state_reg)
                ST_IDLE: fl_alloc_en = grant_fire;
                ST_WAIT: begin
                    if (flush) begin
                        // Flushed allocation: hand a good register back
                        recover_push = fl_alloc_valid;
                    end else begin
                        rsp_fail = !fl_alloc_valid;
                        rsp_phys = fl_alloc_valid ? fl_alloc_phys : '0;
                    end
                end
                default: fl_alloc_en = 1'b0;
            endcase
        end
    end

    // Per-lane one-hot grant and response strobes
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lane
            assign req_ready[gi] = grant_fire && (grant_lane == 1'(gi));
            assign rsp_valid[gi] = resp_fire  && (owner_reg  == 1'(gi));
        end
    endgenerate

    // Commit frees are held off during flush and whenever two slots are not free
    assign cm_free_ready = reset ||
                           (!flush && (count_reg <= CNT_W'(FREEQ_DEPTH - 2)));

    // Select what enters the queue this cycle; recovery and commit never overlap
    always_comb begin
        push_cnt   = 2'd0;
        push_data0 = '0;
        push_data1 = '0;
        if (recover_push) begin
            push_cnt   = 2'd1;
            push_data0 = fl_alloc_phys;
        end else if (!reset && cm_free_ready) begin
            case (cm_free_valid)
                2'b01: begin
                    push_cnt   = 2'd1;
                    push_data0 = cm_free_phys0;
                end
                2'b10: begin
                    push_cnt   = 2'd1;
                    push_data0 = cm_free_phys1;
                end
                2'b11: begin
                    push_cnt   = 2'd2;
                    push_data0 = cm_free_phys0;
                    push_data1 = cm_free_phys1;
                end
                default: push_cnt = 2'd0;
            endcase
        end
    end

    // Drain the head entry whenever the queue holds anything
    assign pop        = (count_reg != '0);
    assign head_next  = pop ? head_reg + PTR_W'(1) : head_reg;
    assign tail_next  = tail_reg + PTR_W'(push_cnt);
    assign count_next = count_reg + CNT_W'(push_cnt) - CNT_W'(pop);

    // Queue pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    // Queue storage; contents need no reset because count gates every read
    always_ff @(posedge clk) begin
        if (push_cnt != 2'd0) begin
            fq_mem[tail_reg] <= push_data0;
        end
        if (push_cnt == 2'd2) begin
            fq_mem[tail_reg + PTR_W'(1)] <= push_data1;
        end
    end

    assign fl_free_en   = !reset && pop;
    assign fl_free_phys = fl_free_en ? fq_mem[head_reg] : '0;
    assign busy         = !reset && ((state_reg == ST_WAIT) || (count_reg != '0));

endmodule

// File: tb/tb_preg_alloc_ctrl.sv
// Bench for preg_alloc_ctrl: directed vectors with literal checks, plus a
// queue-based reference model compared against every output each cycle.
module tb_preg_alloc_ctrl;

    localparam int PREG_W = 6;
    localparam int DEPTH  = 8;

    logic              clk;
    logic              reset;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [1:0]        rsp_valid;
    logic [PREG_W-1:0] rsp_phys;
    logic              rsp_fail;
    logic              fl_alloc_en;
    logic [PREG_W-1:0] fl_alloc_phys;
    logic              fl_alloc_valid;
    logic [1:0]        cm_free_valid;
    logic [PREG_W-1:0] cm_free_phys0;
    logic [PREG_W-1:0] cm_free_phys1;
    logic              cm_free_ready;
    logic              fl_free_en;
    logic [PREG_W-1:0] fl_free_phys;
    logic              flush;
    logic              busy;

    int errors = 0;
    int checks = 0;

    preg_alloc_ctrl #(.PREG_W(PREG_W), .FREEQ_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_phys(rsp_phys), .rsp_fail(rsp_fail),
        .fl_alloc_en(fl_alloc_en), .fl_alloc_phys(fl_alloc_phys),
        .fl_alloc_valid(fl_alloc_valid),
        .cm_free_valid(cm_free_valid), .cm_free_phys0(cm_free_phys0),
        .cm_free_phys1(cm_free_phys1), .cm_free_ready(cm_free_ready),
        .fl_free_en(fl_free_en), .fl_free_phys(fl_free_phys),
        .flush(flush), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int   fq[$];        // registers waiting to be released, oldest first
    bit   m_pend;       // an allocation response is due this cycle
    bit   m_own;
    bit   m_pri;
    bit   m_g;
    int   drained[$];
    bit   log_drain = 1'b0;
    logic [1:0]        e_rr, e_rv;
    logic              e_ae, e_fail, e_cr, e_fe, e_busy;
    logic [PREG_W-1:0] e_ph, e_fp;

    // Compare every output against the model, then advance the model
    always @(negedge clk) begin
        e_rr = 2'b00; e_rv = 2'b00; e_ae = 1'b0; e_fail = 1'b0;
        e_ph = '0; e_fe = 1'b0; e_fp = '0; e_busy = 1'b0; e_cr = 1'b1;
        m_g  = 1'b0;
        if (reset) begin
            m_pend = 1'b0; m_pri = 1'b0; m_own = 1'b0;
            fq.delete();
        end else begin
            if (!m_pend) begin
                if (!flush && req_valid != 2'b00) begin
                    m_g = req_valid[m_pri] ? m_pri : !m_pri;
                    e_rr[m_g] = 1'b1;
                    e_ae = 1'b1;
                end
            end else if (!flush) begin
                e_rv[m_own] = 1'b1;
                e_fail = !fl_alloc_valid;
                e_ph   = fl_alloc_valid ? fl_alloc_phys : '0;
            end
            e_cr = !flush && (fq.size() <= DEPTH - 2);
            if (fq.size() > 0) begin
                e_fe = 1'b1;
                e_fp = PREG_W'(fq[0]);
            end
            e_busy = m_pend || (fq.size() > 0);
        end

        check("req_ready", 32'(req_ready), 32'(e_rr));
        check("fl_alloc_en", 32'(fl_alloc_en), 32'(e_ae));
        check("rsp_valid", 32'(rsp_valid), 32'(e_rv));
        check("rsp_fail", 32'(rsp_fail), 32'(e_fail));
        check("rsp_phys", 32'(rsp_phys), 32'(e_ph));
        check("cm_free_ready", 32'(cm_free_ready), 32'(e_cr));
        check("fl_free_en", 32'(fl_free_en), 32'(e_fe));
        check("fl_free_phys", 32'(fl_free_phys), 32'(e_fp));
        check("busy", 32'(busy), 32'(e_busy));

        if (log_drain && fl_free_en) drained.push_back(int'(fl_free_phys));

        if (!reset) begin
            if (e_fe) void'(fq.pop_front());
            if (m_pend && flush && fl_alloc_valid) fq.push_back(int'(fl_alloc_phys));
            if (e_cr) begin
                if (cm_free_valid[0]) fq.push_back(int'(cm_free_phys0));
                if (cm_free_valid[1]) fq.push_back(int'(cm_free_phys1));
            end
            if (m_pend) begin
                m_pend = 1'b0;
            end else if (e_ae) begin
                m_pend = 1'b1;
                m_own  = m_g;
                m_pri  = !m_g;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic [1:0] rv, input logic [PREG_W-1:0] ap, input logic av,
                        input logic fl, input logic [1:0] cv,
                        input logic [PREG_W-1:0] c0, input logic [PREG_W-1:0] c1);
        @(posedge clk);
        #1;
        req_valid = rv; fl_alloc_phys = ap; fl_alloc_valid = av; flush = fl;
        cm_free_valid = cv; cm_free_phys0 = c0; cm_free_phys1 = c1;
        #1;
        $display("t=%0t rv=%b flush=%b av=%b ap=%0d cv=%b c=%0d/%0d | rr=%b rsp=%b phys=%0d fail=%b cmr=%b free=%b/%0d",
                 $time, rv, fl, av, ap, cv, c0, c1, req_ready, rsp_valid, rsp_phys,
                 rsp_fail, cm_free_ready, fl_free_en, fl_free_phys);
    endtask

    task automatic idle();
        step(2'b00, '0, 1'b0, 1'b0, 2'b00, '0, '0);
    endtask

    int n;
    int accepted;

    initial begin
        reset = 1'b1; req_valid = 2'b11; flush = 1'b0;
        fl_alloc_phys = '0; fl_alloc_valid = 1'b0;
        cm_free_valid = 2'b00; cm_free_phys0 = '0; cm_free_phys1 = '0;
        @(posedge clk); #1;
        check("reset_req_ready", 32'(req_ready), 32'd0);
        check("reset_cm_free_ready", 32'(cm_free_ready), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        req_valid = 2'b00;
        @(posedge clk); #1;
        reset = 1'b0;

        // Alternating grants, responses one cycle later with 3,4,5,6
        for (int k = 0; k < 8; k++) begin
            step(2'b11, PREG_W'(3 + k / 2), 1'b1, 1'b0, 2'b00, '0, '0);
            if (k % 2 == 0) begin
                check("rr_grant", 32'(req_ready), (k % 4 == 0) ? 32'd1 : 32'd2);
            end else begin
                check("rr_rsp_valid", 32'(rsp_valid), (k % 4 == 1) ? 32'd1 : 32'd2);
                check("rr_rsp_phys", 32'(rsp_phys), 32'(3 + k / 2));
            end
        end
        idle();

        // Failed allocation returns phys 0 with fail set
        step(2'b01, '0, 1'b0, 1'b0, 2'b00, '0, '0);
        check("fail_grant", 32'(req_ready), 32'd1);
        step(2'b00, PREG_W'(17), 1'b0, 1'b0, 2'b00, '0, '0);
        check("fail_rsp_valid", 32'(rsp_valid), 32'd1);
        check("fail_flag", 32'(rsp_fail), 32'd1);
        check("fail_phys", 32'(rsp_phys), 32'd0);

        // Flush in IDLE blocks the grant
        step(2'b11, '0, 1'b0, 1'b1, 2'b00, '0, '0);
        check("flush_idle_ready", 32'(req_ready), 32'd0);
        check("flush_idle_alloc_en", 32'(fl_alloc_en), 32'd0);

        // Flush in WAIT recovers the register through the free queue
        step(2'b10, '0, 1'b0, 1'b0, 2'b00, '0, '0);
        check("recov_grant", 32'(req_ready), 32'd2);
        step(2'b00, PREG_W'(9), 1'b1, 1'b1, 2'b00, '0, '0);
        check("recov_rsp_valid", 32'(rsp_valid), 32'd0);
        check("recov_no_bypass", 32'(fl_free_en), 32'd0);
        idle();
        check("recov_free_en", 32'(fl_free_en), 32'd1);
        check("recov_free_phys", 32'(fl_free_phys), 32'd9);
        idle();

        // Back-to-back double commits fill the queue; order must survive
        drained.delete();
        log_drain = 1'b1;
        n = 10;
        accepted = 0;
        for (int i = 0; i < 12; i++) begin
            step(2'b00, '0, 1'b0, 1'b0, 2'b11, PREG_W'(n), PREG_W'(n + 1));
            if (i == 5) check("fill_ready_at_6", 32'(cm_free_ready), 32'd1);
            if (i == 6) check("fill_ready_at_7", 32'(cm_free_ready), 32'd0);
            if (cm_free_ready) begin
                accepted += 2;
                n += 2;
            end
        end
        repeat (12) idle();
        log_drain = 1'b0;
        check("drain_count", 32'(drained.size()), 32'(accepted));
        foreach (drained[i]) check("drain_order", 32'(drained[i]), 32'(10 + i));

        // Reset in WAIT with three entries queued
        step(2'b00, '0, 1'b0, 1'b0, 2'b11, PREG_W'(40), PREG_W'(41));
        step(2'b01, '0, 1'b0, 1'b0, 2'b11, PREG_W'(42), PREG_W'(43));
        check("pre_reset_grant", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1; req_valid = 2'b00; cm_free_valid = 2'b00;
        fl_alloc_phys = PREG_W'(50); fl_alloc_valid = 1'b1;
        #1;
        check("mid_reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_reset_rsp_phys", 32'(rsp_phys), 32'd0);
        check("mid_reset_free_en", 32'(fl_free_en), 32'd0);
        check("mid_reset_free_phys", 32'(fl_free_phys), 32'd0);
        check("mid_reset_cm_ready", 32'(cm_free_ready), 32'd1);
        check("mid_reset_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0; req_valid = 2'b11; fl_alloc_valid = 1'b0;
        #1;
        check("post_reset_grant", 32'(req_ready), 32'd1);
        idle();
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

endmodule
